vector_sequencer: RTL and testbench

//  Sequences the 160-bit compute core over a batch of input vectors held in the input memory.
//  Per vector: issues the vector's base address and a start pulse, waits for the core's done,

---
 rtl/vseq_pkg.sv | 23 ++
 rtl/vseq_watchdog.sv | 41 ++++
 rtl/vector_sequencer.sv | 149 ++++++++++++++
 tb/tb_vector_sequencer.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vseq_pkg.sv
// Shared types and default widths for the vector sequencer.
package vseq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_OUT,
    ST_FINISH
  } state_e;

  localparam int unsigned VSEQ_ADDR_W        = 8;
  localparam int unsigned VSEQ_WORDS_PER_VEC = 10;
  localparam int unsigned VSEQ_NVEC_W        = 4;
  localparam int unsigned VSEQ_Q_W           = 160;
  localparam int unsigned VSEQ_TIMEOUT_CYC   = 1024;

  // Counter width able to hold 0 .. limit-1.
  function automatic int unsigned vseq_cnt_w(input int unsigned limit);
    return (limit < 2) ? 1 : $clog2(limit);
  endfunction

endpackage

// File: rtl/vseq_watchdog.sv
// WAIT-state watchdog for vector_sequencer; only built when VSEQ_TIMEOUT_EN is defined.
`ifdef VSEQ_TIMEOUT_EN
module vseq_watchdog
  import vseq_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = VSEQ_TIMEOUT_CYC
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int unsigned CNT_W = vseq_cnt_w(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Fires on the TIMEOUT_CYC-th enabled cycle after a clear.
  assign expired_o = enable_i && (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && !expired_o) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`endif

// File: rtl/vector_sequencer.sv
// Steps the compute core through a batch of input vectors and hands each result downstream.
// Optional WAIT watchdog and sticky err flag enabled by defining VSEQ_TIMEOUT_EN.
module vector_sequencer
  import vseq_pkg::*;
#(
  parameter int unsigned ADDR_W        = VSEQ_ADDR_W,
  parameter int unsigned WORDS_PER_VEC = VSEQ_WORDS_PER_VEC,
  parameter int unsigned NVEC_W        = VSEQ_NVEC_W,
  parameter int unsigned Q_W           = VSEQ_Q_W
`ifdef VSEQ_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYC   = VSEQ_TIMEOUT_CYC
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [NVEC_W-1:0] num_vec,
  output logic [ADDR_W-1:0] core_addr,
  output logic              core_start,
  input  logic              core_done,
  input  logic [Q_W-1:0]    core_q,
  output logic [Q_W-1:0]    q,
  output logic              q_valid,
  input  logic              q_ready,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_e            state_q;
  logic [NVEC_W-1:0] num_vec_q;
  logic [NVEC_W-1:0] vec_idx_q;
  logic [NVEC_W-1:0] vec_idx_d;
  logic [ADDR_W-1:0] core_addr_q;
  logic [ADDR_W-1:0] core_addr_d;
  logic              core_start_q;
  logic [Q_W-1:0]    result_q;
  logic              q_valid_q;
  logic              busy_q;
  logic              done_q;
  logic              last_vec;
  logic              wd_expired;

  assign vec_idx_d   = vec_idx_q + NVEC_W'(1);
  // Base address wraps silently in ADDR_W bits.
  assign core_addr_d = ADDR_W'(vec_idx_q) * ADDR_W'(WORDS_PER_VEC);
  assign last_vec    = (vec_idx_d == num_vec_q);

`ifdef VSEQ_TIMEOUT_EN
  logic err_q;

  vseq_watchdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_watchdog (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (state_q == ST_ISSUE),
    .enable_i  (state_q == ST_WAIT),
    .expired_o (wd_expired)
  );

  assign err = err_q;
`else
  assign wd_expired = 1'b0;
  assign err        = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      num_vec_q    <= '0;
      vec_idx_q    <= '0;
      core_addr_q  <= '0;
      core_start_q <= 1'b0;
      result_q     <= '0;
      q_valid_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
`ifdef VSEQ_TIMEOUT_EN
      err_q        <= 1'b0;
`endif
    end else begin
      core_start_q <= 1'b0;
      done_q       <= 1'b0;
      // Abort outranks every other event, including a same-cycle core_done or handshake.
      if (abort && (state_q != ST_IDLE)) begin
        state_q   <= ST_IDLE;
        q_valid_q <= 1'b0;
        busy_q    <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (start) begin
              num_vec_q <= num_vec;
              vec_idx_q <= '0;
              busy_q    <= 1'b1;
`ifdef VSEQ_TIMEOUT_EN
              err_q     <= 1'b0;
`endif
              state_q   <= (num_vec == '0) ? ST_FINISH : ST_ISSUE;
            end
          end
          ST_ISSUE: begin
            core_addr_q  <= core_addr_d;
            core_start_q <= 1'b1;
            state_q      <= ST_WAIT;
          end
          ST_WAIT: begin
            if (core_done) begin
              result_q  <= core_q;
              q_valid_q <= 1'b1;
              state_q   <= ST_OUT;
            end else if (wd_expired) begin
`ifdef VSEQ_TIMEOUT_EN
              err_q     <= 1'b1;
`endif
              state_q   <= ST_FINISH;
            end
          end
          ST_OUT: begin
            if (q_ready) begin
              q_valid_q <= 1'b0;
              vec_idx_q <= vec_idx_d;
              state_q   <= last_vec ? ST_FINISH : ST_ISSUE;
            end
          end
          ST_FINISH: begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign core_addr  = core_addr_q;
  assign core_start = core_start_q;
  assign q          = result_q;
  assign q_valid    = q_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_vector_sequencer.sv
// Directed bench for vector_sequencer: table of batches plus hand-written abort/reset/timeout cases.
module tb_vector_sequencer;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic [3:0]   num_vec = '0;
  logic [7:0]   core_addr;
  logic         core_start;
  logic         core_done = 1'b0;
  logic [159:0] core_q = '0;
  logic [159:0] q;
  logic         q_valid;
  logic         q_ready = 1'b0;
  logic         busy;
  logic         done;
  logic         err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  vector_sequencer #(
    .ADDR_W        (8),
    .WORDS_PER_VEC (10),
    .NVEC_W        (4),
    .Q_W           (160)
`ifdef VSEQ_TIMEOUT_EN
    ,
    .TIMEOUT_CYC   (16)
`endif
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .num_vec    (num_vec),
    .core_addr  (core_addr),
    .core_start (core_start),
    .core_done  (core_done),
    .core_q     (core_q),
    .q          (q),
    .q_valid    (q_valid),
    .q_ready    (q_ready),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  typedef struct {
    logic [3:0]      nvec;
    int              lat;
    int              rdyw;
    logic [3:0][7:0] addr;
  } batch_t;

  batch_t tbl[4];

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [159:0] pat(input int b, input int v);
    logic [7:0] bb, vv;
    bb = b[7:0];
    vv = v[7:0];
    return {5{16'hC0DE, bb, vv}};
  endfunction

  task automatic wait_core_start(input string nm);
    int n = 0;
    while (core_start !== 1'b1 && n < 8) begin
      tick();
      n++;
    end
    chk(nm, n, 1);
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while (done !== 1'b1 && n < 8) begin
      tick();
      n++;
    end
    chk(nm, n, 1);
    chk({nm, "_busy_low"}, busy, 0);
    tick();
    chk({nm, "_one_cycle"}, done, 0);
  endtask

  task automatic run_batch(input batch_t b, input int id);
    logic [159:0] d;
    logic         hold;
    num_vec = b.nvec;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    chk("batch_busy", busy, 1);
    if (b.nvec == 0) begin
      chk("empty_no_core_start", core_start, 0);
    end else begin
      for (int v = 0; v < int'(b.nvec); v++) begin
        wait_core_start("core_start_latency");
        chk("core_addr", core_addr, b.addr[v]);
        d = pat(id, v);
        tick();
        chk("core_start_pulse", core_start, 0);
        repeat (b.lat - 1) tick();
        chk("core_addr_stable", core_addr, b.addr[v]);
        core_done = 1'b1;
        core_q    = d;
        tick();
        core_done = 1'b0;
        core_q    = '0;
        chk("q_valid_rise", q_valid, 1);
        chk("q_data", q, d);
        hold = 1'b1;
        repeat (b.rdyw) begin
          tick();
          if (q !== d || q_valid !== 1'b1 || core_start !== 1'b0) hold = 1'b0;
        end
        if (b.rdyw > 0) chk("q_hold_no_ready", hold, 1);
        q_ready = 1'b1;
        tick();
        q_ready = 1'b0;
        chk("q_valid_drop", q_valid, 0);
      end
      chk("finish_busy", busy, 1);
    end
    wait_done("batch_done");
  endtask

  initial begin
    logic seen;
    tbl[0] = '{nvec: 4'd3, lat: 5, rdyw: 0,  addr: {8'd0,  8'd20, 8'd10, 8'd0}};
    tbl[1] = '{nvec: 4'd0, lat: 1, rdyw: 0,  addr: {8'd0,  8'd0,  8'd0,  8'd0}};
    tbl[2] = '{nvec: 4'd2, lat: 1, rdyw: 20, addr: {8'd0,  8'd0,  8'd10, 8'd0}};
    tbl[3] = '{nvec: 4'd4, lat: 2, rdyw: 1,  addr: {8'd30, 8'd20, 8'd10, 8'd0}};

    #12;
    chk("rst_core_addr", core_addr, 0);
    chk("rst_core_start", core_start, 0);
    chk("rst_q", q, 0);
    chk("rst_q_valid", q_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // abort and core_done while idle do nothing
    abort     = 1'b1;
    core_done = 1'b1;
    core_q    = pat(9, 9);
    tick();
    abort     = 1'b0;
    core_done = 1'b0;
    core_q    = '0;
    chk("idle_abort_busy", busy, 0);
    chk("idle_core_done_q_valid", q_valid, 0);
    chk("idle_core_done_q", q, 0);

    for (int i = 0; i < 4; i++) run_batch(tbl[i], i + 1);

    // abort together with core_done on vector 1
    num_vec = 4'd3;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    wait_core_start("abort_v0_start");
    tick();
    core_done = 1'b1;
    core_q    = pat(7, 0);
    tick();
    core_done = 1'b0;
    q_ready   = 1'b1;
    tick();
    q_ready   = 1'b0;
    wait_core_start("abort_v1_start");
    chk("abort_v1_addr", core_addr, 10);
    tick();
    core_done = 1'b1;
    abort     = 1'b1;
    core_q    = pat(7, 1);
    tick();
    core_done = 1'b0;
    abort     = 1'b0;
    core_q    = '0;
    chk("abort_q_valid", q_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_q_not_latched", q, pat(7, 0));
    seen = 1'b0;
    repeat (6) begin
      tick();
      if (done !== 1'b0 || core_start !== 1'b0) seen = 1'b1;
    end
    chk("abort_no_done", seen, 0);
    run_batch(tbl[0], 5);

    // start while busy is dropped; async reset mid-WAIT
    num_vec = 4'd2;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    wait_core_start("busy_start_v0");
    tick();
    num_vec = 4'd5;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    chk("busy_start_core_start", core_start, 0);
    chk("busy_start_addr", core_addr, 0);
    core_done = 1'b1;
    core_q    = pat(8, 0);
    tick();
    core_done = 1'b0;
    core_q    = '0;
    q_ready   = 1'b1;
    tick();
    q_ready   = 1'b0;
    wait_core_start("busy_start_v1");
    chk("busy_start_v1_addr", core_addr, 10);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_core_addr", core_addr, 0);
    chk("async_rst_core_start", core_start, 0);
    chk("async_rst_q", q, 0);
    chk("async_rst_q_valid", q_valid, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_done", done, 0);
    chk("async_rst_err", err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post_rst_busy", busy, 0);
    run_batch(tbl[3], 6);

`ifdef VSEQ_TIMEOUT_EN
    begin
      int n;
      logic extra;
      num_vec = 4'd2;
      start   = 1'b1;
      tick();
      start   = 1'b0;
      wait_core_start("to_core_start");
      n     = 0;
      extra = 1'b0;
      while (done !== 1'b1 && n < 40) begin
        tick();
        n++;
        if (core_start !== 1'b0) extra = 1'b1;
      end
      chk("to_done_latency", n, 17);
      chk("to_err_set", err, 1);
      chk("to_skip_rest", extra, 0);
      tick();
      chk("to_err_sticky", err, 1);
      num_vec = 4'd0;
      start   = 1'b1;
      tick();
      start   = 1'b0;
      chk("to_err_cleared", err, 0);
      wait_done("to_clear_done");
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
